// File: rtl/updown_request_generator_pkg.sv
// ============================================================================
// Module      : updown_request_generator_pkg
// Description : Shared request-FSM encodings and default debounce length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package updown_request_generator_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    localparam logic [1:0] REQ_IDLE         = 2'b00;
    localparam logic [1:0] REQ_UP           = 2'b01;
    localparam logic [1:0] REQ_DOWN         = 2'b10;
    localparam logic [1:0] REQ_WAIT_RELEASE = 2'b11;

endpackage

`default_nettype wire

// File: rtl/updown_request_generator_button_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : 2-flop synchronizer, stability counter and press-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_button,
    output logic o_press
);

    localparam int                CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             db_q, db_d;
    logic             db_prev_q, db_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d      = i_button;
        s2_d      = s1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        cnt_d     = '0;
        // The level only moves after s2 has disagreed for DEBOUNCE_CYCLES cycles in a row.
        if (s2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d  = s2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_press = db_q & ~db_prev_q;

endmodule

`default_nettype wire

// File: rtl/updown_request_generator.sv
// ============================================================================
// Module      : updown_request_generator
// Description : Debounced button presses turned into handshaked up/down steps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_request_generator
    import updown_request_generator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic upButton,
    input  logic downButton,
    input  logic upAck,
    input  logic downAck,
    output logic up,
    output logic down,
    output logic busy,
    output logic dropped
);

    logic       up_press, down_press;
    logic [1:0] state_q, state_d;
    logic       up_q, up_d;
    logic       down_q, down_d;
    logic       dropped_q, dropped_d;
    logic       up_pend_q, up_pend_d;
    logic       down_pend_q, down_pend_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_debouncer (
        .clock    (clock),
        .reset    (reset),
        .i_button (upButton),
        .o_press  (up_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_debouncer (
        .clock    (clock),
        .reset    (reset),
        .i_button (downButton),
        .o_press  (down_press)
    );

    always_comb begin
        state_d     = state_q;
        up_d        = up_q;
        down_d      = down_q;
        dropped_d   = 1'b0;
        up_pend_d   = up_pend_q;
        down_pend_d = down_pend_q;

        case (state_q)
            REQ_IDLE: begin
                if (up_press && down_press) begin
                    dropped_d = 1'b1;
                end else if (up_press || up_pend_q) begin
                    state_d   = REQ_UP;
                    up_d      = 1'b1;
                    // A fresh press alongside a consumed pending one stays queued.
                    up_pend_d = up_press & up_pend_q;
                    if (down_press) begin
                        if (down_pend_q) dropped_d   = 1'b1;
                        else             down_pend_d = 1'b1;
                    end
                end else if (down_press || down_pend_q) begin
                    state_d     = REQ_DOWN;
                    down_d      = 1'b1;
                    down_pend_d = down_press & down_pend_q;
                end
            end
            REQ_UP: begin
                if (upAck) begin
                    up_d    = 1'b0;
                    state_d = REQ_WAIT_RELEASE;
                end
            end
            REQ_DOWN: begin
                if (downAck) begin
                    down_d  = 1'b0;
                    state_d = REQ_WAIT_RELEASE;
                end
            end
            REQ_WAIT_RELEASE: begin
                if (!upAck && !downAck) state_d = REQ_IDLE;
            end
            default: begin
                state_d = REQ_IDLE;
                up_d    = 1'b0;
                down_d  = 1'b0;
            end
        endcase

        // While a step is in flight each direction queues one press; extras are discarded.
        if (state_q != REQ_IDLE) begin
            if (up_press) begin
                if (up_pend_q) dropped_d = 1'b1;
                else           up_pend_d = 1'b1;
            end
            if (down_press) begin
                if (down_pend_q) dropped_d   = 1'b1;
                else             down_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= REQ_IDLE;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            dropped_q   <= 1'b0;
            up_pend_q   <= 1'b0;
            down_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            up_q        <= up_d;
            down_q      <= down_d;
            dropped_q   <= dropped_d;
            up_pend_q   <= up_pend_d;
            down_pend_q <= down_pend_d;
        end
    end

    assign up      = up_q;
    assign down    = down_q;
    assign dropped = dropped_q;
    assign busy    = (state_q != REQ_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_updown_request_generator.sv
// ============================================================================
// Module      : tb_updown_request_generator
// Description : Directed scenarios against a behavioural up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_request_generator;

    logic clock      = 1'b0;
    logic reset      = 1'b1;
    logic upButton   = 1'b0;
    logic downButton = 1'b0;
    logic upAck      = 1'b0;
    logic downAck    = 1'b0;
    logic up, down, busy, dropped;

    int errors = 0;
    int checks = 0;

    // Counter model: acks one cycle after sampling a request; stall holds off acks.
    bit   stall = 1'b0;
    int   count = 0;
    int   up_rises = 0, down_rises = 0, drops = 0;
    logic up_prev = 1'b0, down_prev = 1'b0;

    updown_request_generator #(.DEBOUNCE_CYCLES(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .upButton   (upButton),
        .downButton (downButton),
        .upAck      (upAck),
        .downAck    (downAck),
        .up         (up),
        .down       (down),
        .busy       (busy),
        .dropped    (dropped)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!stall && up && !upAck) begin
            count <= count + 1;
            upAck <= 1'b1;
        end else begin
            upAck <= 1'b0;
        end
        if (!stall && down && !downAck) begin
            count   <= count - 1;
            downAck <= 1'b1;
        end else begin
            downAck <= 1'b0;
        end
    end

    always @(negedge clock) begin
        if (up && !up_prev)     up_rises   <= up_rises + 1;
        if (down && !down_prev) down_rises <= down_rises + 1;
        if (dropped)            drops      <= drops + 1;
        up_prev   <= up;
        down_prev <= down;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_n(3);
        if (up !== 1'b0)      begin errors++; $display("FAIL reset_up: got %b want 0", up); end
        checks++;
        if (down !== 1'b0)    begin errors++; $display("FAIL reset_down: got %b want 0", down); end
        checks++;
        if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b want 0", dropped); end
        checks++;
        reset = 1'b0;
        wait_n(2);
    endtask

    task automatic test_single_press();
        int b_up, b_cnt;
        b_up = up_rises; b_cnt = count;
        upButton = 1'b1;
        wait_n(6);
        if (up !== 1'b0) begin errors++; $display("FAIL single_up_early: got %b want 0 after edge 6", up); end
        checks++;
        wait_n(1);
        if (up !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_up_rise: up=%b busy=%b want 1/1 after edge 7", up, busy); end
        checks++;
        wait_n(2);
        if (up !== 1'b0) begin errors++; $display("FAIL single_up_fall: got %b want 0 after edge 9", up); end
        checks++;
        wait_n(1);
        if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b want 0 after edge 10", busy); end
        checks++;
        wait_n(10);
        if (up_rises - b_up !== 1) begin errors++; $display("FAIL single_rises: got %0d want 1", up_rises - b_up); end
        checks++;
        if (count - b_cnt !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", count - b_cnt); end
        checks++;
        upButton = 1'b0;
        wait_n(10);
    endtask

    task automatic test_bounce();
        int b_up, b_cnt;
        b_up = up_rises; b_cnt = count;
        for (int i = 0; i < 12; i++) begin
            upButton = ((i % 4) < 2);
            wait_n(1);
        end
        wait_n(3);
        if (up_rises - b_up !== 0 || up !== 1'b0) begin errors++; $display("FAIL bounce_reject: rises=%0d up=%b want 0/0", up_rises - b_up, up); end
        checks++;
        upButton = 1'b1;
        wait_n(6);
        if (up !== 1'b0) begin errors++; $display("FAIL bounce_early: got %b want 0 after edge 6", up); end
        checks++;
        wait_n(1);
        if (up !== 1'b1) begin errors++; $display("FAIL bounce_rise: got %b want 1 after edge 7", up); end
        checks++;
        wait_n(12);
        if (up_rises - b_up !== 1 || count - b_cnt !== 1) begin errors++; $display("FAIL bounce_once: rises=%0d count=%0d want 1/1", up_rises - b_up, count - b_cnt); end
        checks++;
        upButton = 1'b0;
        wait_n(10);
    endtask

    task automatic test_queued_presses();
        int b_up, b_dn, b_cnt, b_drop;
        b_up = up_rises; b_dn = down_rises; b_cnt = count; b_drop = drops;
        stall = 1'b1;
        upButton = 1'b1;
        wait_n(7);
        if (up !== 1'b1) begin errors++; $display("FAIL queued_up_busy: up=%b want 1", up); end
        checks++;
        downButton = 1'b1;
        wait_n(6);
        downButton = 1'b0;
        wait_n(6);
        downButton = 1'b1;
        wait_n(6);
        if (dropped !== 1'b0) begin errors++; $display("FAIL queued_drop_early: got %b want 0", dropped); end
        checks++;
        wait_n(1);
        if (dropped !== 1'b1) begin errors++; $display("FAIL queued_drop_pulse: got %b want 1", dropped); end
        checks++;
        wait_n(1);
        if (dropped !== 1'b0 || down !== 1'b0) begin errors++; $display("FAIL queued_drop_width: dropped=%b down=%b want 0/0", dropped, down); end
        checks++;
        stall = 1'b0;
        upButton = 1'b0;
        wait_n(20);
        if (up_rises - b_up !== 1 || down_rises - b_dn !== 1) begin errors++; $display("FAIL queued_requests: up=%0d down=%0d want 1/1", up_rises - b_up, down_rises - b_dn); end
        checks++;
        if (count - b_cnt !== 0 || drops - b_drop !== 1) begin errors++; $display("FAIL queued_net: count=%0d drops=%0d want 0/1", count - b_cnt, drops - b_drop); end
        checks++;
        downButton = 1'b0;
        wait_n(10);
    endtask

    task automatic test_pending_priority();
        int b_cnt, b_drop;
        b_cnt = count; b_drop = drops;
        stall = 1'b1;
        downButton = 1'b1;
        wait_n(7);
        if (down !== 1'b1) begin errors++; $display("FAIL prio_down_busy: down=%b want 1", down); end
        checks++;
        upButton = 1'b1;
        downButton = 1'b0;
        wait_n(6);
        downButton = 1'b1;
        wait_n(9);
        if (busy !== 1'b1 || drops - b_drop !== 0) begin errors++; $display("FAIL prio_queued: busy=%b drops=%0d want 1/0", busy, drops - b_drop); end
        checks++;
        stall = 1'b0;
        wait_n(3);
        if (up !== 1'b0) begin errors++; $display("FAIL prio_up_early: got %b want 0", up); end
        checks++;
        wait_n(1);
        if (up !== 1'b1 || down !== 1'b0) begin errors++; $display("FAIL prio_up_first: up=%b down=%b want 1/0", up, down); end
        checks++;
        wait_n(3);
        if (down !== 1'b0) begin errors++; $display("FAIL prio_down_early: got %b want 0", down); end
        checks++;
        wait_n(1);
        if (down !== 1'b1 || up !== 1'b0) begin errors++; $display("FAIL prio_down_second: down=%b up=%b want 1/0", down, up); end
        checks++;
        wait_n(10);
        if (count - b_cnt !== -1) begin errors++; $display("FAIL prio_net: got %0d want -1", count - b_cnt); end
        checks++;
        upButton = 1'b0;
        downButton = 1'b0;
        wait_n(10);
    endtask

    task automatic test_simultaneous();
        int b_up, b_dn, b_drop;
        b_up = up_rises; b_dn = down_rises; b_drop = drops;
        upButton = 1'b1;
        downButton = 1'b1;
        wait_n(6);
        if (dropped !== 1'b0) begin errors++; $display("FAIL simul_drop_early: got %b want 0", dropped); end
        checks++;
        wait_n(1);
        if (dropped !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL simul_drop: dropped=%b busy=%b want 1/0", dropped, busy); end
        checks++;
        wait_n(1);
        if (dropped !== 1'b0) begin errors++; $display("FAIL simul_drop_width: got %b want 0", dropped); end
        checks++;
        wait_n(10);
        if (up_rises - b_up !== 0 || down_rises - b_dn !== 0 || drops - b_drop !== 1) begin
            errors++;
            $display("FAIL simul_none: up=%0d down=%0d drops=%0d want 0/0/1", up_rises - b_up, down_rises - b_dn, drops - b_drop);
        end
        checks++;
        upButton = 1'b0;
        downButton = 1'b0;
        wait_n(10);
    endtask

    task automatic test_reset_mid_handshake();
        stall = 1'b1;
        upButton = 1'b1;
        wait_n(8);
        if (up !== 1'b1) begin errors++; $display("FAIL rstmid_up_before: got %b want 1", up); end
        checks++;
        reset = 1'b1;
        wait_n(1);
        if (up !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_clear: up=%b busy=%b want 0/0", up, busy); end
        checks++;
        reset = 1'b0;
        wait_n(6);
        if (up !== 1'b0) begin errors++; $display("FAIL rstmid_early: got %b want 0", up); end
        checks++;
        wait_n(1);
        if (up !== 1'b1) begin errors++; $display("FAIL rstmid_repress: got %b want 1", up); end
        checks++;
        stall = 1'b0;
        wait_n(6);
        upButton = 1'b0;
        wait_n(10);
        if (busy !== 1'b0 || up !== 1'b0) begin errors++; $display("FAIL rstmid_final: busy=%b up=%b want 0/0", busy, up); end
        checks++;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_single_press();
        test_bounce();
        test_queued_presses();
        test_pending_priority();
        test_simultaneous();
        test_reset_mid_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/updown_request_generator.md
# updown_request_generator

Upstream stage for the up/down counter. Converts two raw, bouncing push-button inputs into clean `up`/`down` request levels. Each request is held under a four-phase handshake against the counter's `upAck`/`downAck`, so every debounced press produces exactly one count step. Presses that arrive while a step is in flight are queued one-deep per direction.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a synchronized button level is accepted. Legal range is 2 and up.
- `clock` input, 1 bit: single clock domain.
- `reset` input, 1 bit: synchronous, active-high. Clears all state on the rising clock edge at which it is sampled high.
- `upButton` input, 1 bit: raw asynchronous up button, active-high.
- `downButton` input, 1 bit: raw asynchronous down button, active-high.
- `upAck` input, 1 bit: from the counter; high for one cycle after an increment.
- `downAck` input, 1 bit: from the counter; high for one cycle after a decrement.
- `up` output, 1 bit: registered increment request to the counter.
- `down` output, 1 bit: registered decrement request to the counter.
- `busy` output, 1 bit: high whenever the FSM is not in REQ_IDLE.
- `dropped` output, 1 bit: one-cycle pulse when a press is discarded.

## Operation
- **Synchronizer.** Each button passes through a 2-flop synchronizer (`s1`, `s2`). Both flops reset to 0.
- **Debouncer.** One per button: a level register `db` (reset 0) and a counter `cnt` of width $clog2(DEBOUNCE_CYCLES), reset 0.
  - If `s2 != db`: when `cnt == DEBOUNCE_CYCLES-1`, set `db <= s2` and `cnt <= 0`; otherwise `cnt <= cnt+1`.
  - If `s2 == db`: `cnt <= 0`.
- **Press detection.** A press is `db & ~dbPrev`, where `dbPrev` is `db` delayed one cycle (reset 0). Releases generate no event.
- **Pending flags.** `upPend` and `downPend`, reset 0.
  - A press while not in REQ_IDLE sets the matching flag.
  - A press whose flag is already set is discarded and pulses `dropped`.
- **Request FSM**, reset to REQ_IDLE:
  - **REQ_IDLE.** Sources are checked in this order:
    - Up and down presses in the same cycle: both are ignored and `dropped` pulses.
    - Otherwise a press or a pending flag selects the next request, with up taking priority over down. The consumed pending flag is cleared.
    - Up selected: go to REQ_UP and set `up <= 1`. Down selected: go to REQ_DOWN and set `down <= 1`.
  - **REQ_UP.** Hold `up=1` until `upAck` is sampled high. Then set `up <= 0` and go to REQ_WAIT_RELEASE.
  - **REQ_DOWN.** Symmetric to REQ_UP, using `downAck`.
  - **REQ_WAIT_RELEASE.** Stay until `upAck` and `downAck` are both sampled low, then go to REQ_IDLE.
- **Output exclusivity.** `up` and `down` are never high together.
- **Stray acknowledges.** An ack seen in REQ_IDLE, or the opposite ack seen in REQ_UP/REQ_DOWN, is ignored.
- **Reset mid-request.** `up`, `down`, `dropped` and `busy` are 0 from the first cycle after the reset edge. All pending flags, debouncers and synchronizers are cleared. A button still held after reset registers as a new press once it has re-debounced.

## Timing
- **Reset values.** All outputs are 0 after reset.
- **Press latency.** Raw button high before edge 1, counter idle, nothing pending:
  - `s2=1` after edge 2.
  - `db=1` after edge 2+DEBOUNCE_CYCLES.
  - `up=1` after edge 3+DEBOUNCE_CYCLES.
- **Handshake.** `up` rises at edge E. The counter increments at E+1 and `upAck` is high in the following cycle. This FSM samples `upAck` at E+2, so `up=0` after E+2. `upAck` is low after E+2, and REQ_IDLE is reached after E+3.
- **Step rate.** Minimum spacing between successive request rising edges is 4 cycles.
- **Bounce rejection.** Glitches shorter than DEBOUNCE_CYCLES cycles on `s2` never change `db`.
- **`dropped` timing.** Asserted in the cycle following the offending press detection; width exactly 1 cycle.

## Structure
- **Shared package.** State encodings REQ_IDLE=2'b00, REQ_UP=2'b01, REQ_DOWN=2'b10, REQ_WAIT_RELEASE=2'b11, plus the default DEBOUNCE_CYCLES constant.
- **Sub-module `button_debouncer`.** Contains synchronizer, stability counter, `db` and press-pulse output. Parameterized by DEBOUNCE_CYCLES and instantiated twice.
- **Top level.** Holds the pending flags, the FSM and the output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and a behavioural counter model that acks one cycle after sampling a request.
- **Single press.** Clean `upButton` high at edge 1, held 20 cycles -> `up` high after edge 7, `up` low after edge 9, exactly one `upAck`, counter +1. No second step while the button stays held.
- **Bounce.** `upButton` toggles every 2 cycles for 12 cycles, then is stable high -> no request until 4 stable cycles past the synchronizer; exactly one increment.
- **Queued presses.** Two `downButton` presses arriving while REQ_UP is busy -> second one `dropped=1` for 1 cycle; exactly one `down` request issued after the up handshake completes. Net counter change +1 -1 = 0.
- **Simultaneous presses.** Both buttons pressed on the same edge -> neither request is issued and `dropped` pulses once.
- **Pending priority.** `upPend` and `downPend` both set when the FSM reaches REQ_IDLE -> `up` request first, `down` 4 cycles later.
- **Reset mid-handshake.** `reset` high for 1 cycle while in REQ_UP with `up=1` -> `up=0` and `busy=0` after that edge. A still-held button produces a new `up` 7 edges after reset is released.
